parking_ctrl_multi: RTL and testbench

Parametrised parking-lot controller. Debounces raw entry and exit car sensors and tracks occupancy against a configurable capacity. Drives entry and exit gate controls with timed open/hold. Rejects entries when full and flags exits when empty. Also generates a divided display clock on clk_out; all other logic runs in the clk_in domain.

---
 rtl/parking_pkg.sv | 15 +
 rtl/sensor_debounce.sv | 52 +++++
 rtl/parking_ctrl_multi.sv | 182 ++++++++++++++++++
 tb/tb_parking_ctrl_multi.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking-lot controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    HOLD = 2'd2
  } gate_state_t;

  localparam int DEF_CAPACITY  = 8;
  localparam int DEF_DEBOUNCE  = 4;
  localparam int DEF_GATE_OPEN = 8;
  localparam int DEF_DIV_HALF  = 5;

endpackage

// File: rtl/sensor_debounce.sv
// Raw sensor conditioning: 2-flop synchroniser, stability filter and a
// one-cycle pulse on each accepted rising edge of the filtered level.
module sensor_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int STAB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE - 1);

  logic              sync_p0;
  logic              sync_p1;
  logic [STAB_W-1:0] stab_cnt;

  // Stage p0/p1: bring the asynchronous sensor into the clk_in domain.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Filter: adopt the synchronised level once it has disagreed for DEBOUNCE cycles in a row.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      stab_cnt <= '0;
      level    <= 1'b0;
      rise     <= 1'b0;
    end else if (sync_p1 != level) begin
      if (stab_cnt == STAB_LAST) begin
        stab_cnt <= '0;
        level    <= sync_p1;
        rise     <= sync_p1;
      end else begin
        stab_cnt <= stab_cnt + STAB_W'(1);
        rise     <= 1'b0;
      end
    end else begin
      stab_cnt <= '0;
      rise     <= 1'b0;
    end
  end

endmodule

// File: rtl/parking_ctrl_multi.sv
// Parking-lot controller: debounced entry/exit sensors, occupancy count,
// timed entry/exit gates and a free-running divided display clock.
module parking_ctrl_multi
  import parking_pkg::*;
#(
  parameter int CAPACITY  = DEF_CAPACITY,
  parameter int CNT_W     = $clog2(CAPACITY + 1),
  parameter int DEBOUNCE  = DEF_DEBOUNCE,
  parameter int GATE_OPEN = DEF_GATE_OPEN,
  parameter int DIV_HALF  = DEF_DIV_HALF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             car_enter,
  input  logic             car_exit,
  output logic [CNT_W-1:0] spots,
  output logic [CNT_W-1:0] occupied,
  output logic             full,
  output logic             empty,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic             entry_reject,
  output logic             exit_error,
  output logic             clk_out
);

  localparam int TMR_W = $clog2(GATE_OPEN + 1);
  localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_OPEN);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);

  logic entry_level, entry_evt;
  logic exit_level,  exit_evt;

  gate_state_t      entry_state, exit_state;
  logic [TMR_W-1:0] entry_tmr,   exit_tmr;

  logic             entry_ok, exit_ok;
  logic             entry_acc, exit_acc;
  logic [CNT_W-1:0] occ_next;
  logic [DIV_W-1:0] div_cnt;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_entry_db (
    .clk_in (clk_in),
    .reset  (reset),
    .raw    (car_enter),
    .level  (entry_level),
    .rise   (entry_evt)
  );

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit_db (
    .clk_in (clk_in),
    .reset  (reset),
    .raw    (car_exit),
    .level  (exit_level),
    .rise   (exit_evt)
  );

  // Acceptance: events count only while the gate is idle; a same-cycle exit frees room at full.
  always_comb begin
    entry_ok  = entry_evt && (entry_state == IDLE);
    exit_ok   = exit_evt  && (exit_state  == IDLE);
    exit_acc  = exit_ok  && (occupied != '0);
    entry_acc = entry_ok && ((occupied != CAP) || exit_acc);
    occ_next  = occupied;
    if (entry_acc && !exit_acc) begin
      occ_next = occupied + CNT_W'(1);
    end else if (exit_acc && !entry_acc) begin
      occ_next = occupied - CNT_W'(1);
    end
  end

  // Occupancy and derived status, all registered together one edge after the event.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      occupied     <= '0;
      spots        <= CAP;
      full         <= 1'b0;
      empty        <= 1'b1;
      entry_reject <= 1'b0;
      exit_error   <= 1'b0;
    end else begin
      occupied     <= occ_next;
      spots        <= CAP - occ_next;
      full         <= (occ_next == CAP);
      empty        <= (occ_next == '0);
      entry_reject <= entry_ok && !entry_acc;
      exit_error   <= exit_ok  && !exit_acc;
    end
  end

  // Entry gate: open for GATE_OPEN cycles, then hold while a car is still on the sensor.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      entry_state <= IDLE;
      entry_tmr   <= '0;
      entry_gate  <= 1'b0;
    end else begin
      case (entry_state)
        IDLE: begin
          if (entry_acc) begin
            entry_state <= OPEN;
            entry_tmr   <= TMR_LOAD;
            entry_gate  <= 1'b1;
          end
        end
        OPEN: begin
          if (entry_tmr == TMR_W'(1)) begin
            entry_state <= HOLD;
            entry_tmr   <= '0;
          end else begin
            entry_tmr <= entry_tmr - TMR_W'(1);
          end
        end
        HOLD: begin
          if (!entry_level) begin
            entry_state <= IDLE;
            entry_gate  <= 1'b0;
          end
        end
        default: begin
          entry_state <= IDLE;
          entry_tmr   <= '0;
          entry_gate  <= 1'b0;
        end
      endcase
    end
  end

  // Exit gate: same open/hold sequence driven by accepted exits.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      exit_state <= IDLE;
      exit_tmr   <= '0;
      exit_gate  <= 1'b0;
    end else begin
      case (exit_state)
        IDLE: begin
          if (exit_acc) begin
            exit_state <= OPEN;
            exit_tmr   <= TMR_LOAD;
            exit_gate  <= 1'b1;
          end
        end
        OPEN: begin
          if (exit_tmr == TMR_W'(1)) begin
            exit_state <= HOLD;
            exit_tmr   <= '0;
          end else begin
            exit_tmr <= exit_tmr - TMR_W'(1);
          end
        end
        HOLD: begin
          if (!exit_level) begin
            exit_state <= IDLE;
            exit_gate  <= 1'b0;
          end
        end
        default: begin
          exit_state <= IDLE;
          exit_tmr   <= '0;
          exit_gate  <= 1'b0;
        end
      endcase
    end
  end

  // Display clock divider: toggle every DIV_HALF clk_in cycles, independent of the sensors.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      clk_out <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      clk_out <= ~clk_out;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_parking_ctrl_multi.sv
// Bench for parking_ctrl_multi: table of sensor transactions with a queue of
// expected outcomes, plus hand-written reset, latency and divider sequences.
module tb_parking_ctrl_multi;

  localparam int CAP = 4;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       car_enter = 1'b0;
  logic       car_exit = 1'b0;
  logic [2:0] spots;
  logic [2:0] occupied;
  logic       full, empty, entry_gate, exit_gate, entry_reject, exit_error, clk_out;

  parking_ctrl_multi #(
    .CAPACITY  (CAP),
    .DEBOUNCE  (4),
    .GATE_OPEN (8),
    .DIV_HALF  (5)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .car_enter    (car_enter),
    .car_exit     (car_exit),
    .spots        (spots),
    .occupied     (occupied),
    .full         (full),
    .empty        (empty),
    .entry_gate   (entry_gate),
    .exit_gate    (exit_gate),
    .entry_reject (entry_reject),
    .exit_error   (exit_error),
    .clk_out      (clk_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int en_len;
    int ex_len;
    int occ;
    int rej;
    int err;
    int eg;
    int xg;
  } vec_t;

  vec_t vecs[14];
  vec_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Cumulative high-cycle counters sampled on the falling edge.
  int rej_cyc = 0;
  int err_cyc = 0;
  int eg_cyc  = 0;
  int xg_cyc  = 0;

  always @(negedge clk_in) begin
    if (entry_reject) rej_cyc++;
    if (exit_error)   err_cyc++;
    if (entry_gate)   eg_cyc++;
    if (exit_gate)    xg_cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    int   rb, eb, gb, xb, n;
    vec_t e;
    rb = rej_cyc; eb = err_cyc; gb = eg_cyc; xb = xg_cyc;
    sb_q.push_back(v);
    car_enter = (v.en_len > 0);
    car_exit  = (v.ex_len > 0);
    n = (v.en_len > v.ex_len) ? v.en_len : v.ex_len;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (c == v.en_len) car_enter = 1'b0;
      if (c == v.ex_len) car_exit  = 1'b0;
    end
    repeat (40) tick();
    e = sb_q.pop_front();
    check($sformatf("v%0d occupied", idx), int'(occupied), e.occ);
    check($sformatf("v%0d spots", idx), int'(spots), CAP - e.occ);
    check($sformatf("v%0d full", idx), int'(full), (e.occ == CAP) ? 1 : 0);
    check($sformatf("v%0d empty", idx), int'(empty), (e.occ == 0) ? 1 : 0);
    check($sformatf("v%0d reject_cycles", idx), rej_cyc - rb, e.rej);
    check($sformatf("v%0d error_cycles", idx), err_cyc - eb, e.err);
    check($sformatf("v%0d entry_gate_opened", idx), (eg_cyc - gb > 0) ? 1 : 0, e.eg);
    check($sformatf("v%0d exit_gate_opened", idx), (xg_cyc - xb > 0) ? 1 : 0, e.xg);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_rise, second_rise, first_gate, gate_hi, occ6, occ7, spots7, gb;
    logic prev_clk;

    //            en  ex  occ rej err eg xg
    vecs[0]  = '{  3,  0,  0,  0,  0, 0, 0};  // glitch below DEBOUNCE
    vecs[1]  = '{  0, 10,  0,  0,  1, 0, 0};  // exit while empty
    vecs[2]  = '{ 20,  0,  1,  0,  0, 1, 0};
    vecs[3]  = '{ 10,  0,  2,  0,  0, 1, 0};
    vecs[4]  = '{  6,  0,  3,  0,  0, 1, 0};
    vecs[5]  = '{  4,  0,  4,  0,  0, 1, 0};  // exactly DEBOUNCE cycles
    vecs[6]  = '{ 10,  0,  4,  1,  0, 0, 0};  // entry at full
    vecs[7]  = '{ 10, 10,  4,  0,  0, 1, 1};  // simultaneous at full
    vecs[8]  = '{  0, 10,  3,  0,  0, 0, 1};
    vecs[9]  = '{  2,  2,  3,  0,  0, 0, 0};  // both glitch
    vecs[10] = '{  0, 10,  2,  0,  0, 0, 1};
    vecs[11] = '{  0, 10,  1,  0,  0, 0, 1};
    vecs[12] = '{  0, 10,  0,  0,  0, 0, 1};
    vecs[13] = '{ 10, 10,  1,  0,  1, 1, 0};  // simultaneous at empty

    // Reset held for 3 cycles
    repeat (3) tick();
    check("rst occupied", int'(occupied), 0);
    check("rst spots", int'(spots), CAP);
    check("rst empty", int'(empty), 1);
    check("rst full", int'(full), 0);
    check("rst gates", int'({entry_gate, exit_gate}), 0);
    check("rst clk_out", int'(clk_out), 0);

    // Release and measure the divider
    reset = 1'b1;
    first_rise = -1; second_rise = -1; prev_clk = clk_out;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (clk_out && !prev_clk) begin
        if (first_rise < 0) first_rise = k;
        else if (second_rise < 0) second_rise = k;
      end
      prev_clk = clk_out;
    end
    check("clk_out first_rise", first_rise, 5);
    check("clk_out period", second_rise - first_rise, 10);
    check("post-release spots", int'(spots), CAP);

    // Transaction table
    for (int i = 0; i < 14; i++) apply(vecs[i], i);

    // Fresh reset, then entry latency and gate duration
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    car_enter = 1'b1;
    first_gate = -1; gate_hi = 0; occ6 = -1; occ7 = -1; spots7 = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (entry_gate && first_gate < 0) first_gate = k;
      if (entry_gate) gate_hi++;
      if (k == 6) occ6 = int'(occupied);
      if (k == 7) begin
        occ7   = int'(occupied);
        spots7 = int'(spots);
      end
      if (k == 20) car_enter = 1'b0;
    end
    check("latency gate_first_edge", first_gate, 7);
    check("latency occupied_before", occ6, 0);
    check("latency occupied_after", occ7, 1);
    check("latency spots_after", spots7, 3);
    check("gate open_cycles", gate_hi, 20);

    // Second entry, then asynchronous reset while the gate is open
    car_enter = 1'b1;
    repeat (10) tick();
    check("pre-reset occupied", int'(occupied), 2);
    check("pre-reset entry_gate", int'(entry_gate), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async entry_gate", int'(entry_gate), 0);
    check("async occupied", int'(occupied), 0);
    check("async spots", int'(spots), CAP);
    check("async empty", int'(empty), 1);
    car_enter = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    gb = eg_cyc;
    repeat (40) tick();
    check("after-reset occupied", int'(occupied), 0);
    check("after-reset gate_cycles", eg_cyc - gb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
